// File: rtl/fir_output_stage.sv
// Purpose : FIR back-end; re-attaches sample timing, drops fill, rounds half-to-even, saturates, queues output.
// Latency : sample_valid_i at t -> out_valid_o at t+FIR_LATENCY+3 (FIFO empty, out_ready_i high).
// Backpr. : never stalls the FIR; a result arriving at a full FIFO with no pop is dropped and overflow_o is set.
module fir_output_stage #(
    parameter int CHAIN_WIDTH  = 42,
    parameter int OUT_WIDTH    = 18,
    parameter int FRAC_SHIFT   = 17,
    parameter int FIR_LATENCY  = 24,
    parameter int TAPS         = 44,
    parameter int DISCARD_FILL = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   sample_valid_i,
    input  logic [CHAIN_WIDTH-1:0] chain_i,
    output logic [OUT_WIDTH-1:0]   out_data_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   overflow_o,
    output logic [15:0]            sat_cnt_o
);

    localparam int QW = CHAIN_WIDTH - FRAC_SHIFT;   // integer part after the shift
    localparam int RW = QW + 1;                     // plus a guard bit so rounding cannot wrap
    localparam int FW = $clog2(TAPS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [FW-1:0]         FILL_LAST = FW'(TAPS - 1);
    localparam logic [FRAC_SHIFT-1:0] HALF      = FRAC_SHIFT'(1) << (FRAC_SHIFT - 1);
    localparam logic signed [RW-1:0]  SAT_MAX   = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0]  SAT_MIN   = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic [FIR_LATENCY-1:0] vsr_q, vsr_d;
    logic                   v0, keep;
    logic [FW-1:0]          fill_q, fill_d;

    logic signed [QW-1:0]   q_floor;
    logic [FRAC_SHIFT-1:0]  frac;
    logic                   round_up;
    logic signed [RW-1:0]   s1_dat_q, s1_dat_d;
    logic                   s1_vld_q;

    logic [OUT_WIDTH-1:0]   s2_dat_q, s2_dat_d;
    logic                   s2_sat_q, s2_sat_d, s2_vld_q;

    logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OUT_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic                   fifo_empty, fifo_full, pop, push_ok, drop;
    logic                   ovf_q, ovf_d;
    logic [15:0]            sat_cnt_q, sat_cnt_d;

    // Valid delay line and fill-transient qualification of the chain output.
    always_comb begin
        vsr_d  = (vsr_q << 1) | FIR_LATENCY'(sample_valid_i);
        v0     = vsr_q[FIR_LATENCY-1];
        keep   = v0 && ((DISCARD_FILL == 0) || (fill_q == FILL_LAST));
        fill_d = fill_q;
        if (v0 && (fill_q != FILL_LAST)) begin
            fill_d = fill_q + 1'b1;
        end
    end

    // Stage 1: floor shift, then round half to even on the discarded fraction.
    always_comb begin
        q_floor  = chain_i[CHAIN_WIDTH-1:FRAC_SHIFT];
        frac     = chain_i[FRAC_SHIFT-1:0];
        round_up = (frac > HALF) || ((frac == HALF) && q_floor[0]);
        s1_dat_d = {q_floor[QW-1], q_floor} + RW'(round_up);
    end

    // Stage 2: clamp the rounded value into the output range.
    always_comb begin
        s2_sat_d = 1'b1;
        if (s1_dat_q > SAT_MAX) begin
            s2_dat_d = SAT_MAX[OUT_WIDTH-1:0];
        end else if (s1_dat_q < SAT_MIN) begin
            s2_dat_d = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            s2_dat_d = s1_dat_q[OUT_WIDTH-1:0];
            s2_sat_d = 1'b0;
        end
    end

    // FIFO control: a push into a full FIFO is only accepted if the head leaves in the same cycle.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = !fifo_empty && out_ready_i;
        push_ok    = s2_vld_q && (!fifo_full || pop);
        drop       = s2_vld_q && fifo_full && !pop;
        wr_ptr_d   = wr_ptr_q + (AW+1)'(push_ok);
        rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
        ovf_d      = ovf_q | drop;
        sat_cnt_d  = sat_cnt_q;
        if (s2_vld_q && s2_sat_q && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    // Control and pipeline state; flush clears everything a reset would.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vsr_q     <= '0;
            fill_q    <= '0;
            s1_vld_q  <= 1'b0;
            s1_dat_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_dat_q  <= '0;
            s2_sat_q  <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            sat_cnt_q <= '0;
        end else if (flush_i) begin
            vsr_q     <= '0;
            fill_q    <= '0;
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_sat_q  <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            vsr_q     <= vsr_d;
            fill_q    <= fill_d;
            s1_vld_q  <= keep;
            s1_dat_q  <= s1_dat_d;
            s2_vld_q  <= s1_vld_q;
            s2_dat_q  <= s2_dat_d;
            s2_sat_q  <= s2_sat_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    // FIFO storage; contents are only observable through a valid head, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= s2_dat_q;
        end
    end

    assign out_valid_o = !fifo_empty;
    assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign overflow_o  = ovf_q;
    assign sat_cnt_o   = sat_cnt_q;

endmodule

// File: tb/tb_fir_output_stage.sv
// Bench for fir_output_stage with default parameters (latency 24, 44 taps, 18-bit out, shift 17, depth 4).
// Directed vectors; a queue-level model is compared with the DUT on every falling edge.
// Collected handshakes are also compared against hand-computed literals.
module tb_fir_output_stage;

    localparam int L   = 24;
    localparam int TPS = 44;

    logic        clk_i = 1'b0;
    logic        rst_ni, flush_i, sample_valid_i, out_ready_i;
    logic [41:0] chain_i;
    logic [17:0] out_data_o;
    logic        out_valid_o, overflow_o;
    logic [15:0] sat_cnt_o;

    always #5 clk_i = ~clk_i;

    fir_output_stage dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .sample_valid_i (sample_valid_i),
        .chain_i        (chain_i),
        .out_data_o     (out_data_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .overflow_o     (overflow_o),
        .sat_cnt_o      (sat_cnt_o)
    );

    int     total = 0;
    int     bad   = 0;
    int     tcyc  = 0;
    longint stim_val;
    longint sched [longint];

    typedef struct {
        longint e;
        longint v;
        bit     s;
    } pend_t;

    pend_t  pend [$];
    longint mq [$];
    bit     m_ovf;
    int     m_sat;
    int     npulse;
    longint ecnt = 0;
    pend_t  mp;
    longint mr;

    longint got [$];
    int     first_vld_cyc = -1;

    task automatic check(input string name, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, want, tcyc);
        end
    endtask

    // Mathematical round-half-to-even of x / 2^17.
    function automatic longint rnd(input longint x);
        longint q, f;
        q = x >>> 17;
        f = x & 64'h1FFFF;
        if (f > 65536 || (f == 65536 && q[0])) q = q + 1;
        return q;
    endfunction

    function automatic longint clampv(input longint r);
        if (r > 131071) return 131071;
        if (r < -131072) return -131072;
        return r;
    endfunction

    // Queue-level model: kept pulses arrive in the FIFO L+2 edges after their cycle.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend.delete(); mq.delete();
            m_ovf = 0; m_sat = 0; npulse = 0;
        end else begin
            ecnt++;
            if (flush_i) begin
                pend.delete(); mq.delete();
                m_ovf = 0; m_sat = 0; npulse = 0;
            end else begin
                if (mq.size() > 0 && out_ready_i) void'(mq.pop_front());
                if (pend.size() > 0 && pend[0].e == ecnt) begin
                    mp = pend.pop_front();
                    if (mp.s && m_sat < 65535) m_sat++;
                    if (mq.size() < 4) mq.push_back(mp.v);
                    else m_ovf = 1;
                end
                if (sample_valid_i) begin
                    if (npulse >= TPS - 1) begin
                        mr   = rnd(stim_val);
                        mp.v = clampv(mr);
                        mp.s = (mp.v != mr);
                        mp.e = ecnt + L + 2;
                        pend.push_back(mp);
                    end else begin
                        npulse++;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            check("rst_valid", longint'(out_valid_o), 0);
            check("rst_data", longint'(out_data_o), 0);
            check("rst_overflow", longint'(overflow_o), 0);
            check("rst_satcnt", longint'(sat_cnt_o), 0);
        end else begin
            check("valid", longint'(out_valid_o), longint'(mq.size() > 0));
            if (mq.size() > 0) check("data", longint'($signed(out_data_o)), mq[0]);
            check("overflow", longint'(overflow_o), longint'(m_ovf));
            check("satcnt", longint'(sat_cnt_o), longint'(m_sat));
            if (out_valid_o && out_ready_i) got.push_back(longint'($signed(out_data_o)));
            if (out_valid_o && first_vld_cyc < 0) first_vld_cyc = tcyc;
        end
    end

    task automatic tick(input bit sv, input longint v, input bit rdy, input bit fl);
        longint tmp;
        sample_valid_i = sv;
        stim_val       = v;
        out_ready_i    = rdy;
        flush_i        = fl;
        if (sv) sched[tcyc + L] = v;
        if (sched.exists(tcyc)) tmp = sched[tcyc];
        else tmp = {$urandom, $urandom};
        chain_i = tmp[41:0];
        @(posedge clk_i);
        #1;
        tcyc++;
    endtask

    longint kv [7]   = '{64'h70000, 64'h50000, -64'sh50000, 64'h60000,
                         64'sh4_0000_0000, -64'sh100_0000_0000, 64'h3FFFF};
    longint kexp [7] = '{4, 2, -2, 3, 131071, -131072, 2};
    int     t0;

    initial begin
        rst_ni = 1'b1; flush_i = 1'b0; sample_valid_i = 1'b0; out_ready_i = 1'b0;
        chain_i = '0; stim_val = 0;
        #1 rst_ni = 1'b0;
        repeat (3) tick(0, 0, 0, 0);
        rst_ni = 1'b1;
        repeat (2) tick(0, 0, 1, 0);

        // Model pinned against hand-computed values.
        check("model_0x70000", clampv(rnd(64'h70000)), 4);
        check("model_0x50000", clampv(rnd(64'h50000)), 2);
        check("model_-0x50000", clampv(rnd(-64'sh50000)), -2);
        check("model_0x60000", clampv(rnd(64'h60000)), 3);
        check("model_2^34", clampv(rnd(64'sh4_0000_0000)), 131071);
        check("model_-2^40", clampv(rnd(-64'sh100_0000_0000)), -131072);

        // Fill discard, rounding and saturation: 50 pulses, the last 7 are kept.
        got.delete(); first_vld_cyc = -1; t0 = tcyc;
        for (int i = 0; i < 50; i++) tick(1, (i < 43) ? longint'(i * 1000) : kv[i-43], 1, 0);
        repeat (40) tick(0, 0, 1, 0);
        check("fill_count", got.size(), 7);
        for (int i = 0; i < 7; i++) if (i < got.size()) check("fill_value", got[i], kexp[i]);
        check("fill_first_valid_cycle", first_vld_cyc - t0, 43 + L + 3);
        check("fill_satcnt", longint'(sat_cnt_o), 2);

        // Full FIFO with a push and a pop in the same cycle.
        got.delete();
        for (int i = 0; i < 46; i++)
            tick((i < 4) || (i == 10), (i < 4) ? longint'((10 + i) << 17) : longint'(14 << 17), i == 36, 0);
        check("fullpop_overflow", longint'(overflow_o), 0);
        check("fullpop_first_pop", got.size(), 1);
        repeat (10) tick(0, 0, 1, 0);
        check("fullpop_drain_count", got.size(), 5);
        for (int i = 0; i < 5; i++) if (i < got.size()) check("fullpop_value", got[i], 10 + i);

        // Backpressure: 6 kept results into a stalled FIFO, the last 2 are dropped.
        got.delete();
        for (int i = 0; i < 40; i++) tick(i < 6, longint'((21 + i) << 17), 0, 0);
        check("bp_overflow", longint'(overflow_o), 1);
        check("bp_valid_held", longint'(out_valid_o), 1);
        repeat (10) tick(0, 0, 1, 0);
        check("bp_drain_count", got.size(), 4);
        for (int i = 0; i < 4; i++) if (i < got.size()) check("bp_value", got[i], 21 + i);

        // Flush mid-stream, then fill discard restarts.
        for (int i = 0; i < 30; i++) tick(1, longint'((i + 1) << 17), 0, 0);
        check("preflush_satcnt", longint'(sat_cnt_o), 2);
        check("preflush_overflow", longint'(overflow_o), 1);
        tick(1, 0, 0, 1);
        check("flush_valid", longint'(out_valid_o), 0);
        check("flush_overflow", longint'(overflow_o), 0);
        check("flush_satcnt", longint'(sat_cnt_o), 0);
        got.delete();
        for (int i = 0; i < 44; i++) tick(1, (i == 43) ? longint'(7 << 17) : longint'(99 << 17), 1, 0);
        repeat (40) tick(0, 0, 1, 0);
        check("postflush_count", got.size(), 1);
        if (got.size() > 0) check("postflush_value", got[0], 7);

        // Reset mid-stream with saturated results in flight and an overflow pending.
        for (int i = 0; i < 32; i++) tick(1, 64'sh4_0000_0000, 0, 0);
        check("prereset_satcnt", longint'(sat_cnt_o), 6);
        check("prereset_overflow", longint'(overflow_o), 1);
        rst_ni = 1'b0;
        #1;
        check("reset_valid", longint'(out_valid_o), 0);
        check("reset_overflow", longint'(overflow_o), 0);
        check("reset_satcnt", longint'(sat_cnt_o), 0);
        repeat (2) tick(0, 0, 1, 0);
        rst_ni = 1'b1;
        got.delete();
        for (int i = 0; i < 44; i++) tick(1, (i == 43) ? longint'(5 << 17) : longint'(77 << 17), 1, 0);
        repeat (40) tick(0, 0, 1, 0);
        check("postreset_count", got.size(), 1);
        if (got.size() > 0) check("postreset_value", got[0], 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
